// File: rtl/mmio_store_router.sv
// Store-path router: decodes each store into data memory, object registers or unmapped.
// Object stores hit a live bank that is copied to a display shadow bank on frame_ack.
module mmio_store_router #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_BYTES = 1024,
    parameter int NUM_OBJ   = 3,
    parameter int CNT_W     = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      store_en,
    input  logic [ADDR_W-1:0]         address,
    input  logic [DATA_W-1:0]         wdata,
    input  logic                      frame_ack,
    output logic                      writeMemory,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    output logic [NUM_OBJ*DATA_W-1:0] obj_shadow,
    output logic [NUM_OBJ-1:0]        obj_dirty,
    output logic [NUM_OBJ-1:0]        obj_wr,
    output logic                      err_flag,
    output logic [CNT_W-1:0]          err_count
);
    localparam int OBJ_END = MEM_BYTES + 4 * NUM_OBJ;

    logic                             w_in_mem;
    logic                             w_in_obj;
    logic                             w_aligned;
    logic                             w_mem_st;
    logic                             w_err;
    logic [ADDR_W-1:0]                w_off;
    logic [NUM_OBJ-1:0]               w_obj_hit;
    logic [NUM_OBJ-1:0][DATA_W-1:0]   r_live;
    logic [NUM_OBJ-1:0][DATA_W-1:0]   r_shadow;

    // Full-width unsigned compares so high address bits can never alias into a region.
    assign w_in_mem  = address < ADDR_W'(MEM_BYTES);
    assign w_in_obj  = !w_in_mem && (address < ADDR_W'(OBJ_END));
    assign w_aligned = address[1:0] == 2'b00;
    assign w_off     = address - ADDR_W'(MEM_BYTES);
    assign w_mem_st  = store_en && w_in_mem;
    assign w_err     = store_en && !w_in_mem && !(w_in_obj && w_aligned);

    always_comb begin
        w_obj_hit = '0;
        for (int i = 0; i < NUM_OBJ; i++)
            w_obj_hit[i] = store_en && w_in_obj && w_aligned && ((w_off >> 2) == ADDR_W'(i));
    end

    assign obj_shadow = r_shadow;

    always_ff @(posedge clk) begin
        if (rst) begin
            writeMemory <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            r_live      <= '0;
            r_shadow    <= '0;
            obj_dirty   <= '0;
            obj_wr      <= '0;
            err_flag    <= 1'b0;
            err_count   <= '0;
        end else begin
            writeMemory <= w_mem_st;
            if (w_mem_st) begin
                mem_addr  <= address;
                mem_wdata <= wdata;
            end
            obj_wr <= w_obj_hit;
            // Shadow samples pre-edge live, so a same-cycle store lands only in live.
            for (int i = 0; i < NUM_OBJ; i++) begin
                if (frame_ack)    r_shadow[i] <= r_live[i];
                if (w_obj_hit[i]) r_live[i]   <= wdata;
            end
            obj_dirty <= w_obj_hit | (frame_ack ? '0 : obj_dirty);
            if (w_err) begin
                err_flag <= 1'b1;
                if (err_count != '1) err_count <= err_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mmio_store_router.sv
// Directed bench: vector table on a default instance, plus small-counter and 8-object instances.
module tb_mmio_store_router;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // default instance
    logic        a_en, a_fa;
    logic [31:0] a_addr, a_wd;
    logic        a_wm, a_ef;
    logic [31:0] a_ma, a_md;
    logic [95:0] a_sh;
    logic [2:0]  a_dirty, a_wr;
    logic [7:0]  a_ec;

    mmio_store_router u_a (
        .clk(clk), .rst(rst), .store_en(a_en), .address(a_addr), .wdata(a_wd),
        .frame_ack(a_fa), .writeMemory(a_wm), .mem_addr(a_ma), .mem_wdata(a_md),
        .obj_shadow(a_sh), .obj_dirty(a_dirty), .obj_wr(a_wr),
        .err_flag(a_ef), .err_count(a_ec));

    // 2-bit error counter
    logic        b_en, b_fa;
    logic [31:0] b_addr, b_wd;
    logic        b_wm, b_ef;
    logic [31:0] b_ma, b_md;
    logic [95:0] b_sh;
    logic [2:0]  b_dirty, b_wr;
    logic [1:0]  b_ec;

    mmio_store_router #(.CNT_W(2)) u_b (
        .clk(clk), .rst(rst), .store_en(b_en), .address(b_addr), .wdata(b_wd),
        .frame_ack(b_fa), .writeMemory(b_wm), .mem_addr(b_ma), .mem_wdata(b_md),
        .obj_shadow(b_sh), .obj_dirty(b_dirty), .obj_wr(b_wr),
        .err_flag(b_ef), .err_count(b_ec));

    // 8 objects at 256
    logic         c_en, c_fa;
    logic [31:0]  c_addr, c_wd;
    logic         c_wm, c_ef;
    logic [31:0]  c_ma, c_md;
    logic [255:0] c_sh;
    logic [7:0]   c_dirty, c_wr;
    logic [7:0]   c_ec;

    mmio_store_router #(.NUM_OBJ(8), .MEM_BYTES(256)) u_c (
        .clk(clk), .rst(rst), .store_en(c_en), .address(c_addr), .wdata(c_wd),
        .frame_ack(c_fa), .writeMemory(c_wm), .mem_addr(c_ma), .mem_wdata(c_md),
        .obj_shadow(c_sh), .obj_dirty(c_dirty), .obj_wr(c_wr),
        .err_flag(c_ef), .err_count(c_ec));

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        en;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        fa;
        logic        wm;
        logic [31:0] ma;
        logic [31:0] md;
        logic [2:0]  wr;
        logic [2:0]  dirty;
        logic        ef;
        logic [7:0]  ec;
        logic [95:0] sh;
    } vec_t;

    localparam int NV = 20;
    vec_t tbl [NV];

    initial begin
        logic [95:0] s1, s2, s3, s4;
        s1 = {32'h0, 32'h00400030, 32'h0};
        s2 = {32'h0, 32'h00400030, 32'h11};
        s3 = {32'h0, 32'h00400030, 32'h22};
        s4 = {32'hAA, 32'h00400030, 32'h22};
        //            en  addr          wd            fa  wm  ma     md            wr      dirty   ef  ec  sh
        tbl[0]  = '{1'b0, 32'd0,        32'h0,        1'b0, 1'b0, 32'd0,    32'h0,        3'b000, 3'b000, 1'b0, 8'd0, 96'h0};
        tbl[1]  = '{1'b1, 32'd1020,     32'hDEADBEEF, 1'b0, 1'b1, 32'd1020, 32'hDEADBEEF, 3'b000, 3'b000, 1'b0, 8'd0, 96'h0};
        tbl[2]  = '{1'b0, 32'd0,        32'h0,        1'b0, 1'b0, 32'd1020, 32'hDEADBEEF, 3'b000, 3'b000, 1'b0, 8'd0, 96'h0};
        tbl[3]  = '{1'b1, 32'd1028,     32'h00400030, 1'b0, 1'b0, 32'd1020, 32'hDEADBEEF, 3'b010, 3'b010, 1'b0, 8'd0, 96'h0};
        tbl[4]  = '{1'b0, 32'd0,        32'h0,        1'b0, 1'b0, 32'd1020, 32'hDEADBEEF, 3'b000, 3'b010, 1'b0, 8'd0, 96'h0};
        tbl[5]  = '{1'b0, 32'd0,        32'h0,        1'b1, 1'b0, 32'd1020, 32'hDEADBEEF, 3'b000, 3'b000, 1'b0, 8'd0, s1};
        tbl[6]  = '{1'b1, 32'd1024,     32'h11,       1'b0, 1'b0, 32'd1020, 32'hDEADBEEF, 3'b001, 3'b001, 1'b0, 8'd0, s1};
        tbl[7]  = '{1'b0, 32'd0,        32'h0,        1'b1, 1'b0, 32'd1020, 32'hDEADBEEF, 3'b000, 3'b000, 1'b0, 8'd0, s2};
        tbl[8]  = '{1'b1, 32'd1024,     32'h22,       1'b1, 1'b0, 32'd1020, 32'hDEADBEEF, 3'b001, 3'b001, 1'b0, 8'd0, s2};
        tbl[9]  = '{1'b0, 32'd0,        32'h0,        1'b1, 1'b0, 32'd1020, 32'hDEADBEEF, 3'b000, 3'b000, 1'b0, 8'd0, s3};
        tbl[10] = '{1'b1, 32'd1036,     32'h1234,     1'b0, 1'b0, 32'd1020, 32'hDEADBEEF, 3'b000, 3'b000, 1'b1, 8'd1, s3};
        tbl[11] = '{1'b1, 32'd1026,     32'hFFFF,     1'b0, 1'b0, 32'd1020, 32'hDEADBEEF, 3'b000, 3'b000, 1'b1, 8'd2, s3};
        tbl[12] = '{1'b0, 32'd0,        32'h0,        1'b1, 1'b0, 32'd1020, 32'hDEADBEEF, 3'b000, 3'b000, 1'b1, 8'd2, s3};
        tbl[13] = '{1'b0, 32'd1024,     32'h99,       1'b0, 1'b0, 32'd1020, 32'hDEADBEEF, 3'b000, 3'b000, 1'b1, 8'd2, s3};
        tbl[14] = '{1'b1, 32'd0,        32'h5,        1'b0, 1'b1, 32'd0,    32'h5,        3'b000, 3'b000, 1'b1, 8'd2, s3};
        tbl[15] = '{1'b1, 32'd1032,     32'hAA,       1'b0, 1'b0, 32'd0,    32'h5,        3'b100, 3'b100, 1'b1, 8'd2, s3};
        tbl[16] = '{1'b0, 32'd0,        32'h0,        1'b1, 1'b0, 32'd0,    32'h5,        3'b000, 3'b000, 1'b1, 8'd2, s4};
        tbl[17] = '{1'b0, 32'd0,        32'h0,        1'b1, 1'b0, 32'd0,    32'h5,        3'b000, 3'b000, 1'b1, 8'd2, s4};
        tbl[18] = '{1'b1, 32'hFFFFFFFC, 32'h77,       1'b0, 1'b0, 32'd0,    32'h5,        3'b000, 3'b000, 1'b1, 8'd3, s4};
        tbl[19] = '{1'b1, 32'd1023,     32'h7,        1'b0, 1'b1, 32'd1023, 32'h7,        3'b000, 3'b000, 1'b1, 8'd3, s4};

        // reset with garbage on every input
        rst = 1'b1;
        a_en = 1'b1; a_addr = 32'd1024; a_wd = 32'hFFFF; a_fa = 1'b1;
        b_en = 1'b1; b_addr = 32'd5000; b_wd = 32'h1;    b_fa = 1'b1;
        c_en = 1'b1; c_addr = 32'd260;  c_wd = 32'h3;    c_fa = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wm", a_wm, 0);
        chk("rst_wr", a_wr, 0);
        chk("rst_ec", a_ec, 0);
        chk("rst_ef", a_ef, 0);
        chk("rst_sh", a_sh, 0);
        chk("rst_b_ec", b_ec, 0);
        chk("rst_c_wr", c_wr, 0);
        @(negedge clk);
        rst = 1'b0;
        a_en = 1'b0; a_fa = 1'b0; a_addr = '0; a_wd = '0;
        b_en = 1'b0; b_fa = 1'b0;
        c_en = 1'b0; c_fa = 1'b0;

        for (int k = 0; k < NV; k++) begin
            a_en = tbl[k].en; a_addr = tbl[k].addr; a_wd = tbl[k].wd; a_fa = tbl[k].fa;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_wm", k),    a_wm,    tbl[k].wm);
            chk($sformatf("v%0d_ma", k),    a_ma,    tbl[k].ma);
            chk($sformatf("v%0d_md", k),    a_md,    tbl[k].md);
            chk($sformatf("v%0d_wr", k),    a_wr,    tbl[k].wr);
            chk($sformatf("v%0d_dirty", k), a_dirty, tbl[k].dirty);
            chk($sformatf("v%0d_ef", k),    a_ef,    tbl[k].ef);
            chk($sformatf("v%0d_ec", k),    a_ec,    tbl[k].ec);
            chk($sformatf("v%0d_sh", k),    a_sh,    tbl[k].sh);
            @(negedge clk);
        end
        a_en = 1'b0; a_fa = 1'b0;

        // saturation with a 2-bit counter
        for (int k = 1; k <= 5; k++) begin
            b_en = 1'b1; b_addr = 32'd2000 + 32'(k);
            @(posedge clk);
            #1;
            chk($sformatf("sat%0d_ec", k), b_ec, (k > 3) ? 3 : k);
            chk($sformatf("sat%0d_wr", k), {b_wm, b_wr}, 0);
            @(negedge clk);
        end
        b_en = 1'b0;

        // 8 objects, memory region 256 bytes
        c_en = 1'b1; c_addr = 32'd284; c_wd = 32'h77;
        @(posedge clk); #1;
        chk("c_obj7_wr", c_wr, 8'h80);
        chk("c_obj7_dirty", c_dirty, 8'h80);
        chk("c_obj7_ef", c_ef, 0);
        @(negedge clk);
        c_addr = 32'd288; c_wd = 32'h55;
        @(posedge clk); #1;
        chk("c_288_wr", {c_wm, c_wr}, 0);
        chk("c_288_ef", c_ef, 1);
        chk("c_288_ec", c_ec, 1);
        @(negedge clk);
        c_en = 1'b0; c_fa = 1'b1;
        @(posedge clk); #1;
        chk("c_copy_sh", c_sh, {32'h77, 224'h0});
        chk("c_copy_dirty", c_dirty, 0);
        @(negedge clk);
        c_fa = 1'b0; c_en = 1'b1; c_addr = 32'd255; c_wd = 32'h9;
        @(posedge clk); #1;
        chk("c_255_wm", c_wm, 1);
        chk("c_255_ma", c_ma, 255);
        @(negedge clk);
        c_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mmio_store_router.md
Name: mmio_store_router

Overview:
Parametrised store-path router between the processor datapath and the game peripherals. Decodes each store address into one of three regions: data memory, a bank of NUM_OBJ object registers (player/enemies), or unmapped. Stores to data memory are forwarded after one register stage. Object stores land in a live register bank that is copied into a display-side shadow bank on a frame handshake. Unmapped and misaligned object stores are dropped and counted.

Parameters:
ADDR_W, 32, store address width (bits)
DATA_W, 32, store data width (bits)
MEM_BYTES, 1024, size of the data-memory region in bytes; region is [0, MEM_BYTES)
NUM_OBJ, 3, number of 4-byte object registers at [MEM_BYTES, MEM_BYTES+4*NUM_OBJ)
CNT_W, 8, width of the error counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
store_en  in  1  store request valid this cycle
address  in  ADDR_W  unsigned byte address of the store
wdata  in  DATA_W  store data
frame_ack  in  1  1-cycle pulse from the display; requests a live-to-shadow copy
writeMemory  out  1  registered data-memory write strobe
mem_addr  out  ADDR_W  registered memory address
mem_wdata  out  DATA_W  registered memory write data
obj_shadow  out  NUM_OBJ*DATA_W  shadow bank read by the display; object i occupies bits [i*DATA_W +: DATA_W]
obj_dirty  out  NUM_OBJ  bit i set when live object i differs from its shadow since the last copy
obj_wr  out  NUM_OBJ  1-cycle registered strobe when object i is written
err_flag  out  1  sticky; set on any dropped store
err_count  out  CNT_W  saturating count of dropped stores

Behaviour:
- Reset (rst=1 at a clk edge): all outputs, the live bank, the shadow bank and the counter go to 0. Reset overrides every same-cycle input.
- Decode uses a full unsigned ADDR_W compare. It is evaluated only when store_en=1; when store_en=0, nothing changes except the frame_ack copy.
- Memory region (address < MEM_BYTES):
  - Next cycle: writeMemory=1, mem_addr=address, mem_wdata=wdata.
  - Latency is exactly 1 cycle. writeMemory is 0 in every other cycle.
  - mem_addr and mem_wdata hold their last values when writeMemory=0.
  - No alignment check in this region.
- Object region (MEM_BYTES ≤ address < MEM_BYTES+4*NUM_OBJ):
  - Index i = (address-MEM_BYTES)>>2.
  - If address[1:0]==0: live[i] ← wdata; obj_wr[i]=1 for the next cycle only; obj_dirty[i] ← 1.
  - If address[1:0]!=0: the store is dropped as misaligned (error path).
- Unmapped (address ≥ MEM_BYTES+4*NUM_OBJ): dropped (error path).
- Error path, evaluated next cycle:
  - err_flag ← 1, and it stays set until rst.
  - err_count increments by 1 and saturates at 2^CNT_W-1 (no wrap).
  - No write strobe of any kind is asserted.
- Frame copy: on a clk edge with frame_ack=1, every shadow[i] ← live[i] as it was before the edge, and obj_dirty ← 0.
- Simultaneous frame_ack and an object store to index i in the same cycle:
  - shadow[i] takes the pre-store live value.
  - live[i] takes wdata.
  - obj_dirty[i] ends at 1 (the store wins over the clear).
  - Other indices are cleared normally.
- Shadow outputs change only on frame_ack or rst, so the display never sees a partial update mid-frame.
- At most one region is selected per cycle. The object and memory strobes are mutually exclusive.
- A frame_ack held high for several cycles copies on every one of those cycles; it has no other effect.

Test Plan:
- Reset: drive garbage inputs with rst=1 for 2 cycles, then release -> every output is 0, including err_count=0 and obj_shadow all zero.
- Memory store: store_en=1, address=32'd1020, wdata=32'hDEADBEEF -> next cycle writeMemory=1, mem_addr=1020, mem_wdata=DEADBEEF; following cycle writeMemory=0; obj_wr=0 and err_flag=0 throughout.
- Object store and frame copy:
  - Store address=1028, wdata=32'h00400030 -> next cycle obj_wr=3'b010, obj_dirty=3'b010; obj_shadow unchanged (0).
  - Then pulse frame_ack -> obj_shadow[63:32]=32'h00400030, obj_dirty=3'b000.
- Simultaneous events: live[0]=32'h11 already copied; in one cycle store address=1024 with wdata=32'h22 and frame_ack=1 -> shadow[0]=32'h11, live[0]=32'h22, obj_dirty[0]=1. Next frame_ack -> shadow[0]=32'h22.
- Error path:
  - Store to address=1036 (unmapped) -> no strobes; err_flag=1; err_count=1.
  - Then store to address=1026 (misaligned) -> err_count=2; live bank unchanged.
- Saturation and generics:
  - With CNT_W=2, issue 5 unmapped stores -> err_count stays at 3.
  - Re-run the object test with NUM_OBJ=8, MEM_BYTES=256 -> address=256+4*7 strobes obj_wr[7], and address=288 is an error.
